pipe_stage_skid: RTL and testbench

- Parametrised, flow-controlled pipeline stage register for the LEGv8 datapath.
- Generalises the plain EX/MEM latch with a valid/ready handshake, a 2-entry skid buffer, and synchronous flush that squashes control bits.
- Includes a saturating stall counter.
- Drops in between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB); control and datapath fields are packed into CTRL and DATA buses by the instantiating stage.

---
 rtl/pipe_stage_skid.sv | 133 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Flow-controlled pipeline stage register with optional two-entry skid buffer,
// synchronous flush that squashes control bits, and a saturating stall counter.
module pipe_stage_skid #(
    parameter int CTRL_W = 6,
    parameter int DATA_W = 198,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              flush,
    input  logic              clr_stats,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [CTRL_W-1:0]   main_ctrl_reg, skid_ctrl_reg;
    logic [DATA_W-1:0]   main_data_reg, skid_data_reg;
    logic [CNT_W-1:0]    stall_cnt_reg;
    logic                main_valid, skid_valid;
    logic                in_fire, out_fire;
    logic                load_main_in, load_main_skid, load_skid_in;

    // The state encoding doubles as the valid bits of the two entries.
    assign main_valid = (state_reg != ST_EMPTY);
    assign skid_valid = (state_reg == ST_FULL);

    // With the skid buffer, ready depends only on registered state.
    assign in_ready  = (SKID != 0) ? !skid_valid : (!main_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = main_valid && out_ready;

    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl_reg : '0;
    assign out_data  = main_data_reg;
    assign occupancy = state_reg;
    assign stall_cnt = stall_cnt_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: if (in_fire) state_next = ST_ONE;
                ST_ONE: begin
                    if (in_fire && !out_fire)
                        state_next = ST_FULL;
                    else if (!in_fire && out_fire)
                        state_next = ST_EMPTY;
                end
                ST_FULL:  if (out_fire) state_next = ST_ONE;
                default:  state_next = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (!flush) begin
            case (state_reg)
                ST_EMPTY: load_main_in = in_fire;
                ST_ONE: begin
                    load_main_in = in_fire && out_fire;
                    load_skid_in = in_fire && !out_fire;
                end
                ST_FULL:  load_main_skid = out_fire;
                default: ;
            endcase
        end
    end

    // Flush squashes control only; data keeps its last value.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            main_ctrl_reg <= '0;
            main_data_reg <= '0;
            skid_ctrl_reg <= '0;
            skid_data_reg <= '0;
        end else if (flush) begin
            main_ctrl_reg <= '0;
            skid_ctrl_reg <= '0;
        end else begin
            if (load_main_in) begin
                main_ctrl_reg <= in_ctrl;
                main_data_reg <= in_data;
            end else if (load_main_skid) begin
                main_ctrl_reg <= skid_ctrl_reg;
                main_data_reg <= skid_data_reg;
            end
            if (load_skid_in) begin
                skid_ctrl_reg <= in_ctrl;
                skid_data_reg <= in_data;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_cnt_reg <= '0;
        end else if (clr_stats) begin
            stall_cnt_reg <= '0;
        end else if (main_valid && !out_ready && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a skid instance with a 4-bit stall
// counter and a single-register instance, checked with immediate assertions.
module tb_pipe_stage_skid;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;

    logic         a_flush = 0, a_clr = 0, a_in_valid = 0, a_out_ready = 0;
    logic [5:0]   a_in_ctrl = 0;
    logic [197:0] a_in_data = 0;
    logic         a_in_ready, a_out_valid;
    logic [5:0]   a_out_ctrl;
    logic [197:0] a_out_data;
    logic [1:0]   a_occ;
    logic [3:0]   a_stall;

    logic         b_flush = 0, b_clr = 0, b_in_valid = 0, b_out_ready = 0;
    logic [5:0]   b_in_ctrl = 0;
    logic [197:0] b_in_data = 0;
    logic         b_in_ready, b_out_valid;
    logic [5:0]   b_out_ctrl;
    logic [197:0] b_out_data;
    logic [1:0]   b_occ;
    logic [15:0]  b_stall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    pipe_stage_skid #(.CTRL_W(6), .DATA_W(198), .SKID(1), .CNT_W(4)) u_a (
        .CLK(CLK), .RESET(RESET), .flush(a_flush), .clr_stats(a_clr),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl),
        .out_data(a_out_data), .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_stage_skid #(.CTRL_W(6), .DATA_W(198), .SKID(0), .CNT_W(16)) u_b (
        .CLK(CLK), .RESET(RESET), .flush(b_flush), .clr_stats(b_clr),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
        .out_data(b_out_data), .occupancy(b_occ), .stall_cnt(b_stall)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) begin
            $display("check %s = %0h", tag, obs);
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // 1. reset / idle with a valid beat pending on the input
        a_in_valid = 1; a_in_ctrl = 6'h3F;
        step(); step();
        chk("rst_out_valid", 256'(a_out_valid), 256'(0));
        chk("rst_out_ctrl",  256'(a_out_ctrl),  256'(0));
        chk("rst_in_ready",  256'(a_in_ready),  256'(1));
        chk("rst_occ",       256'(a_occ),       256'(0));
        chk("rst_out_data",  256'(a_out_data),  256'(0));
        chk("rst_stall",     256'(a_stall),     256'(0));
        chk("rst_b_in_ready",256'(b_in_ready),  256'(1));
        RESET = 0;
        a_in_ctrl = 6'h01; a_in_data = 198'h1234; a_out_ready = 1;
        step();
        chk("first_valid", 256'(a_out_valid), 256'(1));
        chk("first_data",  256'(a_out_data),  256'h1234);
        chk("first_ctrl",  256'(a_out_ctrl),  256'(1));
        a_in_valid = 0;
        step();
        chk("drain_occ", 256'(a_occ), 256'(0));

        // 2. streaming at full rate
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1; a_in_ctrl = 6'(i); a_in_data = 198'(i * 100);
            step();
            chk("stream_ctrl", 256'(a_out_ctrl), 256'(i));
            chk("stream_data", 256'(a_out_data), 256'(i * 100));
            chk("stream_occ",  256'(a_occ),      256'(1));
        end
        a_in_valid = 0;
        step();
        chk("stream_end_occ", 256'(a_occ),   256'(0));
        chk("stream_stall",   256'(a_stall), 256'(0));

        // 3. back-pressure fills the skid entry
        a_out_ready = 0; a_in_valid = 1; a_in_ctrl = 6'd5; a_in_data = 198'hA5;
        step();
        chk("bp_occ1",   256'(a_occ),      256'(1));
        chk("bp_ready1", 256'(a_in_ready), 256'(1));
        chk("bp_stall0", 256'(a_stall),    256'(0));
        a_in_ctrl = 6'd6; a_in_data = 198'hB6;
        step();
        chk("bp_occ2",   256'(a_occ),      256'(2));
        chk("bp_ready0", 256'(a_in_ready), 256'(0));
        chk("bp_head",   256'(a_out_ctrl), 256'(5));
        chk("bp_stall1", 256'(a_stall),    256'(1));
        a_in_valid = 0;
        step();
        chk("bp_stall2", 256'(a_stall), 256'(2));
        a_out_ready = 1;
        step();
        chk("bp_outB_ctrl", 256'(a_out_ctrl), 256'(6));
        chk("bp_outB_data", 256'(a_out_data), 256'hB6);
        chk("bp_occ_back1", 256'(a_occ),      256'(1));
        chk("bp_ready_back",256'(a_in_ready), 256'(1));
        chk("bp_stall_hold",256'(a_stall),    256'(2));
        step();
        chk("bp_empty_valid", 256'(a_out_valid), 256'(0));
        chk("bp_empty_ctrl",  256'(a_out_ctrl),  256'(0));
        chk("bp_data_kept",   256'(a_out_data),  256'hB6);

        // 4. flush in FULL with a beat offered
        a_out_ready = 0; a_in_valid = 1; a_in_ctrl = 6'h11; a_in_data = 198'hD1;
        step();
        a_in_ctrl = 6'h12; a_in_data = 198'hD2;
        step();
        chk("fl_full", 256'(a_occ), 256'(2));
        a_flush = 1; a_in_ctrl = 6'd7; a_in_data = 198'h777;
        step();
        chk("fl_occ",   256'(a_occ),       256'(0));
        chk("fl_valid", 256'(a_out_valid), 256'(0));
        chk("fl_ctrl",  256'(a_out_ctrl),  256'(0));
        chk("fl_data",  256'(a_out_data),  256'hD1);
        chk("fl_stall", 256'(a_stall),     256'(4));
        // flush while EMPTY discards an accepted beat
        step();
        chk("fl_empty_valid", 256'(a_out_valid), 256'(0));
        chk("fl_empty_data",  256'(a_out_data),  256'hD1);
        a_flush = 0; a_in_valid = 0;
        step();
        chk("fl_no7", 256'(a_out_valid), 256'(0));

        // 5. stall counter saturation and clear
        a_in_valid = 1; a_in_ctrl = 6'd9; a_in_data = 198'h99;
        step();
        a_in_valid = 0;
        repeat (20) step();
        chk("sat_15", 256'(a_stall), 256'(15));
        a_clr = 1;
        step();
        chk("clr_0", 256'(a_stall), 256'(0));
        a_clr = 0;
        step();
        chk("resume_1", 256'(a_stall), 256'(1));
        a_clr = 1; a_flush = 1;
        step();
        chk("both_stall", 256'(a_stall), 256'(0));
        chk("both_occ",   256'(a_occ),   256'(0));
        a_clr = 0; a_flush = 0;

        // 6. single-register mode: combinational ready
        b_out_ready = 0; b_in_valid = 1; b_in_ctrl = 6'd1; b_in_data = 198'h1;
        step();
        chk("s0_occ",    256'(b_occ),      256'(1));
        chk("s0_ready0", 256'(b_in_ready), 256'(0));
        b_out_ready = 1;
        #1;
        chk("s0_ready1", 256'(b_in_ready), 256'(1));
        b_in_ctrl = 6'd2; b_in_data = 198'h2;
        step();
        chk("s0_replace_ctrl", 256'(b_out_ctrl),  256'(2));
        chk("s0_replace_valid",256'(b_out_valid), 256'(1));
        chk("s0_replace_data", 256'(b_out_data),  256'h2);
        chk("s0_stall",        256'(b_stall),     256'(0));
        b_in_valid = 0;

        // asynchronous reset while a beat is held
        a_out_ready = 0; a_in_valid = 1; a_in_ctrl = 6'h15; a_in_data = 198'hABC;
        step();
        chk("ar_loaded", 256'(a_out_valid), 256'(1));
        a_in_valid = 0;
        #2 RESET = 1;
        #1;
        chk("ar_valid", 256'(a_out_valid), 256'(0));
        chk("ar_ctrl",  256'(a_out_ctrl),  256'(0));
        chk("ar_data",  256'(a_out_data),  256'(0));
        chk("ar_occ",   256'(a_occ),       256'(0));
        chk("ar_stall", 256'(a_stall),     256'(0));
        step();
        RESET = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
